// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus: word width, default receive queue
// depth and the bus word type.
package bus_pkg;

   localparam int BUS_W      = 18;
   localparam int FIFO_DEPTH = 4;

   typedef logic [BUS_W-1:0] bus_word_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for the bus receive queue.
// The storage array lives in the parent; this block only says where and when.
module fifo_ctrl #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             outReady,
   input  logic             clrOverflow,
   output logic             push,
   output logic             pop,
   output logic [PTR_W-1:0] wptr,
   output logic [PTR_W-1:0] rptr,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic drop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A pop frees the slot the push needs, so a full queue still accepts a
   // load when the consumer takes the head in the same cycle.
   assign pop  = !empty && outReady;
   assign push = load && (!full || pop);
   assign drop = load && !push;

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + PTR_W'(1);
         if (pop)
            rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         // A fresh drop outranks a clear arriving in the same cycle.
         if (drop)
            overflow <= 1'b1;
         else if (clrOverflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/bus_rx_fifo.sv
// Receive end of the shared datapath bus: captures busIn on load and queues it
// for a downstream consumer, decoupling bus-cycle timing from consumer stalls.
module bus_rx_fifo
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_W,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] busIn,
   input  logic             load,
   output logic [WIDTH-1:0] outData,
   output logic             outValid,
   input  logic             outReady,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   input  logic             clrOverflow
);

   // Handshake: a word transfers at a rising edge where outValid && outReady;
   // outValid never depends on outReady, and outReady without outValid is ignored.

   logic [WIDTH-1:0] mem [DEPTH];
   logic             push;
   logic             pop;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;

   fifo_ctrl #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .outReady    (outReady),
      .clrOverflow (clrOverflow),
      .push        (push),
      .pop         (pop),
      .wptr        (wptr),
      .rptr        (rptr),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .overflow    (overflow)
   );

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= busIn;
   end

   // First-word fall-through; forced to zero when empty so stale storage
   // never shows up on the output.
   assign outValid = !empty;
   assign outData  = empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Bench for bus_rx_fifo: directed vector table, hand sequences for wrap,
// and randomized traffic against a queue-based reference model.
module tb_bus_rx_fifo;

   localparam int W     = 18;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  busIn;
   logic          load;
   logic [W-1:0]  outData;
   logic          outValid;
   logic          outReady;
   logic [2:0]    count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          clrOverflow;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] model_q[$];
   logic         model_ovf;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic         rst;
      logic         ld;
      logic [W-1:0] d;
      logic         rdy;
      logic         clr;
      logic [2:0]   e_cnt;
      logic         e_val;
      logic [W-1:0] e_data;
      logic         e_ovf;
   } vec_t;

   vec_t vt[$];

   bus_rx_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .busIn       (busIn),
      .load        (load),
      .outData     (outData),
      .outValid    (outValid),
      .outReady    (outReady),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .overflow    (overflow),
      .clrOverflow (clrOverflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the queue holds words in arrival order; capacity DEPTH.
   task automatic model_edge(input logic r, input logic ld, input logic [W-1:0] d,
                             input logic rdy, input logic clr);
      bit do_pop, do_push;
      if (r) begin
         model_q.delete();
         model_ovf = 1'b0;
      end else begin
         do_pop  = (model_q.size() > 0) && rdy;
         do_push = ld && ((model_q.size() < DEPTH) || do_pop);
         if (do_pop)
            void'(model_q.pop_front());
         if (do_push)
            model_q.push_back(d);
         if (ld && !do_push)
            model_ovf = 1'b1;
         else if (clr)
            model_ovf = 1'b0;
      end
   endtask

   task automatic compare_model();
      check("count", 32'(count), 32'(model_q.size()));
      check("outValid", 32'(outValid), 32'(model_q.size() > 0));
      check("outData", 32'(outData), (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
      check("full", 32'(full), 32'(model_q.size() == DEPTH));
      check("empty", 32'(empty), 32'(model_q.size() == 0));
      check("overflow", 32'(overflow), 32'(model_ovf));
   endtask

   task automatic step(input logic r, input logic ld, input logic [W-1:0] d,
                       input logic rdy, input logic clr);
      reset       = r;
      load        = ld;
      busIn       = d;
      outReady    = rdy;
      clrOverflow = clr;
      @(posedge clk);
      model_edge(r, ld, d, rdy, clr);
      #1;
      compare_model();
   endtask

   function automatic vec_t mk(input logic rst, input logic ld, input logic [W-1:0] d,
                               input logic rdy, input logic clr, input logic [2:0] e_cnt,
                               input logic e_val, input logic [W-1:0] e_data, input logic e_ovf);
      vec_t v;
      v.rst = rst; v.ld = ld; v.d = d; v.rdy = rdy; v.clr = clr;
      v.e_cnt = e_cnt; v.e_val = e_val; v.e_data = e_data; v.e_ovf = e_ovf;
      return v;
   endfunction

   initial begin
      reset = 1'b1; load = 1'b0; busIn = '0; outReady = 1'b0; clrOverflow = 1'b0;
      model_ovf = 1'b0;

      // Reset and idle
      vt.push_back(mk(1, 0, 18'h0,     0, 0, 0, 0, 18'h0,     0));
      for (int i = 0; i < 5; i++)
         vt.push_back(mk(0, 0, 18'h0,  0, 0, 0, 0, 18'h0,     0));
      // Single capture then pop
      vt.push_back(mk(0, 1, 18'h2A5F0, 0, 0, 1, 1, 18'h2A5F0, 0));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 0, 0, 18'h0,     0));
      // Fill, overflow, drain, clear
      vt.push_back(mk(0, 1, 18'h00001, 0, 0, 1, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h00002, 0, 0, 2, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h00003, 0, 0, 3, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h00004, 0, 0, 4, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h3FFFF, 0, 0, 4, 1, 18'h00001, 1));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 3, 1, 18'h00002, 1));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 2, 1, 18'h00003, 1));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 1, 1, 18'h00004, 1));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 0, 0, 18'h0,     1));
      vt.push_back(mk(0, 0, 18'h0,     0, 1, 0, 0, 18'h0,     0));
      // Push and pop while full
      vt.push_back(mk(0, 1, 18'h00001, 0, 0, 1, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h00002, 0, 0, 2, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h00003, 0, 0, 3, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h00004, 0, 0, 4, 1, 18'h00001, 0));
      vt.push_back(mk(0, 1, 18'h00005, 1, 0, 4, 1, 18'h00002, 0));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 3, 1, 18'h00003, 0));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 2, 1, 18'h00004, 0));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 1, 1, 18'h00005, 0));
      vt.push_back(mk(0, 0, 18'h0,     1, 0, 0, 0, 18'h0,     0));
      // Reset mid-operation with a load in the reset cycle
      vt.push_back(mk(0, 1, 18'h0AAAA, 0, 0, 1, 1, 18'h0AAAA, 0));
      vt.push_back(mk(0, 1, 18'h0BBBB, 0, 0, 2, 1, 18'h0AAAA, 0));
      vt.push_back(mk(0, 1, 18'h0CCCC, 0, 0, 3, 1, 18'h0AAAA, 0));
      vt.push_back(mk(1, 1, 18'h3FFFF, 0, 0, 0, 0, 18'h0,     0));
      vt.push_back(mk(0, 0, 18'h0,     0, 0, 0, 0, 18'h0,     0));

      @(negedge clk);
      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].rst, vt[i].ld, vt[i].d, vt[i].rdy, vt[i].clr);
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
         check($sformatf("vec%0d_valid", i), 32'(outValid), 32'(vt[i].e_val));
         check($sformatf("vec%0d_data", i), 32'(outData), 32'(vt[i].e_data));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].e_ovf));
      end

      // Pointer wrap: stream 10 words, one load and one pop per cycle
      for (int i = 0; i < 10; i++)
         exp_q.push_back(W'(18'h10 + i));
      for (int i = 0; i < 10; i++) begin
         if (i > 0 && outValid)
            check("wrap_word", 32'(outData), 32'(exp_q.pop_front()));
         step(0, 1, W'(18'h10 + i), (i > 0), 0);
         check("wrap_count_le2", 32'(count <= 3'd2), 32'd1);
      end
      for (int n = 0; n < 10 && !empty; n++) begin
         check("wrap_word", 32'(outData), 32'(exp_q.pop_front()));
         step(0, 0, '0, 1, 0);
      end
      check("wrap_all_received", 32'(exp_q.size()), 32'd0);

      // Randomized traffic against the reference queue
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < 60),
              W'($urandom),
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < 8));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_rx_fifo.md
Name: bus_rx_fifo

Overview:
- Receive end of the shared 18-bit tri-state datapath bus.
- Whichever source buffer has its enable asserted drives the bus. This block captures the bus value on a one-cycle load strobe and queues it in a small FIFO.
- Queued words go to a downstream consumer (register file write port, ALU operand latch) over a valid/ready handshake.
- It decouples the bus-cycle timing of the control FSM from consumer stalls.

Parameters:
- WIDTH, 18, bus/data width in bits.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- PTR_W, 2, log2(DEPTH); sizes the read and write pointers.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- busIn  in  WIDTH  shared tri-state bus, sampled only when load=1.
- load  in  1  capture strobe; asserted by control FSM in the same cycle a source enable is asserted.
- outData  out  WIDTH  head-of-queue word.
- outValid  out  1  outData holds a valid word.
- outReady  in  1  consumer accepts outData this cycle.
- count  out  PTR_W+1  number of occupied entries, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky flag: a load was dropped.
- clrOverflow  in  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on the port named reset.
- Reset values (sampled at a clk edge with reset=1):
  - Read and write pointers = 0; count = 0.
  - empty = 1, full = 0, outValid = 0, overflow = 0.
  - outData = 0.
  - Storage contents are don't-care.
- Reset mid-operation: queued data is discarded. A load in the reset cycle is ignored.
- Write: at an edge with load=1 and (not full, or a pop in the same cycle), busIn is written to mem[wptr] and wptr increments modulo DEPTH.
- Read: a pop occurs when outValid && outReady. rptr then increments modulo DEPTH.
- outData/outValid are combinational from mem[rptr] and !empty. There is no output register (first-word fall-through).
- Load-to-outValid latency: 1 cycle. A word loaded at edge N is visible after edge N.
- Simultaneous push and pop:
  - Allowed when full: count is unchanged, the head advances, and the new word is written.
  - When empty, a same-cycle push and pop cannot occur, because outValid=0.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. full/empty are derived from count, not from pointer equality.
- Overflow:
  - load=1 while full with no same-cycle pop: the word is dropped and the FIFO is unchanged.
  - overflow sets at that edge and stays set until clrOverflow=1 or reset.
  - If clrOverflow and a new drop occur in the same cycle, set wins (overflow=1).
- busIn is not qualified beyond load. Sampling a floating bus is a control-FSM error, not detected here.
- outReady with outValid=0 has no effect.

Decomposition:
- Shared package bus_pkg holds:
  - BUS_W = 18.
  - The default FIFO depth constant.
  - A typedef for an 18-bit bus word.
- One natural sub-module: fifo_ctrl. It contains the pointers, count, full/empty and overflow logic, with the storage array kept in bus_rx_fifo.

Test Plan:
1. Reset, then idle: after reset, empty=1, count=0, outValid=0, overflow=0. No change over 5 idle cycles with load=0.
2. Single capture:
   - Stimulus: busIn=18'h2A5F0, load=1 for one cycle, outReady=0.
   - Response: next cycle outValid=1, outData=18'h2A5F0, count=1. With outReady=1 for one cycle, empty=1 and count=0 after the edge.
3. Fill and overflow:
   - Stimulus: load 18'h00001..18'h00004 (full=1), then load 18'h3FFFF with outReady=0.
   - Response: overflow=1, count=4. The pop sequence returns 1,2,3,4, and 18'h3FFFF never appears.
   - Then clrOverflow=1 gives overflow=0.
4. Push and pop while full:
   - Stimulus: full with 1..4, then load 18'h00005 with outReady=1 in the same cycle.
   - Response: count stays 4, overflow=0. Drain order is 2,3,4,5.
5. Pointer wrap: stream 10 words (18'h10..18'h19), one load and one pop per cycle after the first. All 10 are received in order, and count never exceeds 2.
6. Reset mid-operation: with 3 words queued, assert reset with load=1. After reset, count=0, outValid=0, and the loaded word is absent.
